// File: rtl/mem_access_stage_if.sv
// Data-memory port of the memory stage: request/grant address phase plus
// a read-response phase. The stage is the master, the memory is the slave.
interface mem_access_stage_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: retires ALU results directly, performs byte/half/word
// loads and stores over the data-memory port, and emits one registered
// writeback pulse per accepted instruction. Execute is stalled through
// in_ready while a memory transaction is outstanding.
module mem_access_stage #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [31:0]         mem_address,
    input  logic [31:0]         store_data,
    input  logic [31:0]         alu_result,
    input  logic [4:0]          rd,
    mem_access_stage_if.master  dmem,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [31:0]         wb_data,
    output logic                misaligned,
    output logic                bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Illegal size, or an address not aligned to the access size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            2'b10:   return |lo;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Select the addressed lane of the read word and sign/zero-extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    logic              transfer;
    logic              mem_op;
    logic              bad_access;
    logic              timeout_hit;
    logic [CNT_W-1:0]  wait_cnt;

    // Instruction captured at acceptance, used while the memory op is in flight.
    logic              is_load_p1;
    logic [2:0]        funct3_p1;
    logic [1:0]        lo_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [3:0]        be_p1;
    logic [31:0]       wdata_p1;
    logic [4:0]        rd_p1;

    // Writeback record as computed this cycle, and its registered copy.
    logic              vld_nxt, we_nxt, mis_nxt, berr_nxt;
    logic [4:0]        rd_nxt;
    logic [31:0]       data_nxt;
    logic              vld_p2, we_p2, mis_p2, berr_p2;
    logic [4:0]        rd_p2;
    logic [31:0]       data_p2;

    logic              unused_addr_bits;

    assign transfer         = in_valid & in_ready;
    assign mem_op           = is_load | is_store;
    assign bad_access       = is_misaligned(funct3[1:0], mem_address[1:0]);
    assign timeout_hit      = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign unused_addr_bits = ^mem_address[31:ADDR_W+2];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a response on the timeout cycle still counts as a normal return.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (transfer && mem_op && !bad_access) state_nxt = REQ;
            REQ:  if (dmem.gnt) state_nxt = is_load_p1 ? WAIT : IDLE;
            WAIT: if (dmem.rvalid || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port, stall and writeback-record outputs decoded from the state.
    always_comb begin
        in_ready   = (state == IDLE);
        dmem.req   = (state == REQ);
        dmem.we    = (state == REQ) && !is_load_p1;
        dmem.be    = (state == REQ) ? be_p1 : 4'd0;
        dmem.addr  = (state == REQ) ? addr_p1 : '0;
        dmem.wdata = (state == REQ) ? wdata_p1 : 32'd0;
        vld_nxt    = 1'b0;
        we_nxt     = 1'b0;
        mis_nxt    = 1'b0;
        berr_nxt   = 1'b0;
        rd_nxt     = rd_p1;
        data_nxt   = 32'd0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    rd_nxt = rd;
                    if (!mem_op) begin
                        vld_nxt  = 1'b1;
                        we_nxt   = (rd != 5'd0);
                        data_nxt = (rd != 5'd0) ? alu_result : 32'd0;
                    end else if (bad_access) begin
                        vld_nxt = 1'b1;
                        mis_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dmem.gnt && !is_load_p1) vld_nxt = 1'b1;
            end
            WAIT: begin
                if (dmem.rvalid) begin
                    vld_nxt  = 1'b1;
                    we_nxt   = (rd_p1 != 5'd0);
                    data_nxt = (rd_p1 != 5'd0) ? load_extract(funct3_p1, lo_p1, dmem.rdata) : 32'd0;
                end else if (timeout_hit) begin
                    vld_nxt  = 1'b1;
                    berr_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Capture the accepted instruction and its formatted bus fields.
    always_ff @(posedge clk) begin
        if (transfer) begin
            is_load_p1 <= is_load;
            funct3_p1  <= funct3;
            lo_p1      <= mem_address[1:0];
            addr_p1    <= mem_address[ADDR_W+1:2];
            be_p1      <= lane_enables(funct3[1:0], mem_address[1:0]);
            wdata_p1   <= lane_replicate(funct3[1:0], store_data);
            rd_p1      <= rd;
        end
    end

    // Response timeout counter: restarts while requesting, counts idle WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             wait_cnt <= '0;
        else if (state == REQ)                  wait_cnt <= '0;
        else if (state == WAIT && !dmem.rvalid) wait_cnt <= wait_cnt + 1'b1;
    end

    // Writeback stage boundary: control flags are reset, payload is not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            we_p2   <= 1'b0;
            mis_p2  <= 1'b0;
            berr_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_nxt;
            we_p2   <= we_nxt;
            mis_p2  <= mis_nxt;
            berr_p2 <= berr_nxt;
        end
    end

    // Writeback payload registers.
    always_ff @(posedge clk) begin
        rd_p2   <= rd_nxt;
        data_p2 <= data_nxt;
    end

    assign wb_valid   = vld_p2;
    assign wb_we      = we_p2;
    assign misaligned = mis_p2;
    assign bus_error  = berr_p2;
    assign wb_rd      = vld_p2 ? rd_p2 : 5'd0;
    assign wb_data    = we_p2 ? data_p2 : 32'd0;

endmodule
